// File: rtl/eer_pkg.sv
// Shared constants and types for the energy-aware TDMA node: word width, energy costs,
// unassigned-timeslot code and the transmit scheduler state encoding.
package eer_pkg;

  localparam int WORD_WIDTH = 16;

  // Unassigned slot: the node contends at every slot boundary.
  localparam logic [5:0] TIMESLOT_NONE = 6'h3F;

  localparam logic [WORD_WIDTH-1:0] RX_PKT_NRG = 16'd4;

  // Transmit cost indexed by hop class (1..4 hops).
  localparam logic [3:0][WORD_WIDTH-1:0] TX_COST = {16'd27, 16'd17, 16'd9, 16'd5};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_WAIT_SLOT,
    S_BUSY,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/slot_timer.sv
// Free-running TDMA timer: cycle-within-slot counter and frame slot index.
// slotStart is high on the first cycle of every slot.
module slot_timer #(
  parameter int SLOT_CYCLES = 16,
  parameter int FRAME_SLOTS = 32
) (
  input  logic       clk,
  input  logic       nrst,
  output logic [5:0] slotIdx,
  output logic       slotStart
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  logic [CW-1:0] slotCnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slotCnt <= '0;
      slotIdx <= '0;
    end else if (slotCnt == CW'(SLOT_CYCLES - 1)) begin
      slotCnt <= '0;
      slotIdx <= (slotIdx == 6'(FRAME_SLOTS - 1)) ? 6'd0 : slotIdx + 6'd1;
    end else begin
      slotCnt <= slotCnt + CW'(1);
    end
  end

  assign slotStart = (slotCnt == '0);

endmodule

// File: rtl/tx_slot_scheduler.sv
// Per-node TDMA transmit sequencer: round-robin source arbitration, slot wait, one-cycle
// okToSend, completion/timeout tracking. Define ENERGY_ACCT_EN to enable energy accounting.
module tx_slot_scheduler
  import eer_pkg::*;
#(
  parameter int                    N_REQ        = 2,
  parameter int                    SLOT_CYCLES  = 16,
  parameter int                    FRAME_SLOTS  = 32,
  parameter int                    TX_TIMEOUT   = 64,
  parameter logic [WORD_WIDTH-1:0] E_INIT       = 16'h8000,
  parameter logic [WORD_WIDTH-1:0] LOW_E_THRESH = 16'h0800
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [N_REQ-1:0]      req,
  input  logic                  role,
  input  logic [5:0]            timeslot,
  input  logic [1:0]            tx_setting,
  input  logic                  tx_done,
  input  logic                  rx_pulse,
  output logic [N_REQ-1:0]      grant,
  output logic                  okToSend,
  output logic [N_REQ-1:0]      grant_done,
  output logic                  tx_abort,
  output logic [5:0]            slot_idx,
  output logic [WORD_WIDTH-1:0] myEnergy,
  output logic                  low_E
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  sched_state_e   stateReg, stateNext;
  logic [N_REQ-1:0] grantReg, grantNext;
  logic [PW-1:0]  rrPtrReg, rrPtrNext;
  logic [TW-1:0]  busyCntReg;
  logic [N_REQ-1:0] effReq;
  logic [PW-1:0]  winnerIdx;
  logic           anyWin;
  logic [5:0]     slotIdx;
  logic           slotStart;
  logic           mySlot;

  slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .FRAME_SLOTS (FRAME_SLOTS)
  ) uSlotTimer (
    .clk       (clk),
    .nrst      (nrst),
    .slotIdx   (slotIdx),
    .slotStart (slotStart)
  );

  // A cluster head also owns slot 0 in addition to its assigned slot.
  assign mySlot = slotStart &&
                  ((timeslot == TIMESLOT_NONE) || (slotIdx == timeslot) ||
                   (role && (slotIdx == 6'd0)));

  // Round-robin: scanning downwards lets the rrPtr offset (k=0) win last.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    winnerIdx = '0;
    anyWin    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rrPtrReg) + k) % N_REQ);
      if (effReq[idx]) begin
        anyWin    = 1'b1;
        winnerIdx = idx;
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    grantNext = grantReg;
    rrPtrNext = rrPtrReg;
    okToSend  = 1'b0;
    tx_abort  = 1'b0;
    case (stateReg)
      S_IDLE: begin
        if (|effReq) stateNext = S_ARB;
      end
      S_ARB: begin
        if (anyWin) begin
          grantNext            = '0;
          grantNext[winnerIdx] = 1'b1;
          rrPtrNext = (int'(winnerIdx) == N_REQ - 1) ? '0 : winnerIdx + PW'(1);
          stateNext = S_WAIT_SLOT;
        end else begin
          stateNext = S_IDLE;
        end
      end
      S_WAIT_SLOT: begin
        // A withdrawn request abandons the slot silently.
        if (!(|(req & grantReg))) begin
          grantNext = '0;
          stateNext = S_IDLE;
        end else if (mySlot) begin
          okToSend  = 1'b1;
          stateNext = S_BUSY;
        end
      end
      S_BUSY: begin
        if (tx_done) begin
          stateNext = S_DONE;
        end else if (busyCntReg == TW'(TX_TIMEOUT - 1)) begin
          tx_abort  = 1'b1;
          stateNext = S_DONE;
        end
      end
      S_DONE: begin
        grantNext = '0;
        stateNext = S_IDLE;
      end
      default: begin
        grantNext = '0;
        stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stateReg   <= S_IDLE;
      grantReg   <= '0;
      rrPtrReg   <= '0;
      busyCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      grantReg   <= grantNext;
      rrPtrReg   <= rrPtrNext;
      busyCntReg <= (stateReg == S_BUSY) ? busyCntReg + TW'(1) : '0;
    end
  end

  assign grant      = ((stateReg == S_WAIT_SLOT) || (stateReg == S_BUSY)) ? grantReg : '0;
  assign grant_done = (stateReg == S_DONE) ? grantReg : '0;
  assign slot_idx   = slotIdx;

`ifdef ENERGY_ACCT_EN
  logic [WORD_WIDTH-1:0] energyReg, energyCost;
  logic                  lowEReg;

  always_comb begin
    energyCost = '0;
    if (rx_pulse) energyCost = RX_PKT_NRG;
    if (okToSend) energyCost = energyCost + TX_COST[tx_setting];
  end

  // Saturating debit; low_E follows the stored energy with one cycle of lag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      energyReg <= E_INIT;
      lowEReg   <= 1'b0;
    end else begin
      energyReg <= (energyReg > energyCost) ? energyReg - energyCost : '0;
      lowEReg   <= (energyReg < LOW_E_THRESH);
    end
  end

  assign myEnergy = energyReg;
  assign low_E    = lowEReg;

  // Own sensor data (source 1) is starved when energy is low; responses still go out.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : gReqMask
    if (gi == 1) begin : gMasked
      assign effReq[gi] = req[gi] & ~lowEReg;
    end else begin : gPass
      assign effReq[gi] = req[gi];
    end
  end
`else
  logic unusedEnergyInputs;
  assign unusedEnergyInputs = ^{rx_pulse, tx_setting, LOW_E_THRESH, RX_PKT_NRG, TX_COST};
  assign myEnergy = E_INIT;
  assign low_E    = 1'b0;
  assign effReq   = req;
`endif

endmodule

// File: tb/tb_tx_slot_scheduler.sv
// Self-checking bench for tx_slot_scheduler: time-indexed reference model, per-cycle
// compare process, directed literal scenarios and a randomized phase.
module tb_tx_slot_scheduler;

  localparam int SLOT = 16;
  localparam int FRAME = 32;
  localparam int TOUT = 64;
  localparam logic [15:0] EINIT = 16'h8000;
  localparam logic [15:0] ETH = 16'h0800;
  localparam int P_IDLE = 0, P_ARB = 1, P_WAIT = 2, P_BUSY = 3, P_DONE = 4;
`ifdef ENERGY_ACCT_EN
  localparam logic [15:0] T4_E = 16'h7FE1;
`else
  localparam logic [15:0] T4_E = 16'h8000;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic [1:0] req = 2'b00;
  logic role = 1'b0;
  logic [5:0] timeslot = 6'h3F;
  logic [1:0] txSetting = 2'd0;
  logic txDone = 1'b0;
  logic rxPulse = 1'b0;

  wire [1:0] grant, grantDone;
  wire okToSend, txAbort, lowE;
  wire [5:0] slotIdx;
  wire [15:0] myEnergy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_slot_scheduler dut (
    .clk        (clk),
    .nrst       (nrst),
    .req        (req),
    .role       (role),
    .timeslot   (timeslot),
    .tx_setting (txSetting),
    .tx_done    (txDone),
    .rx_pulse   (rxPulse),
    .grant      (grant),
    .okToSend   (okToSend),
    .grant_done (grantDone),
    .tx_abort   (txAbort),
    .slot_idx   (slotIdx),
    .myEnergy   (myEnergy),
    .low_E      (lowE)
  );

  // Reference model: time since reset gives the slot position; a transaction is
  // tracked by its phase, owner and the cycle its strobe went out.
  int mT = 0;
  int mPh = P_IDLE;
  int mOwner = 0;
  int mRr = 0;
  int mOkT = 0;
  logic [15:0] mE = EINIT;
  logic mLow = 1'b0;

  function automatic logic [1:0] effReqF();
`ifdef ENERGY_ACCT_EN
    return mLow ? (req & 2'b01) : req;
`else
    return req;
`endif
  endfunction

  function automatic bit mySlotF();
    int s;
    s = (mT / SLOT) % FRAME;
    if ((mT % SLOT) != 0) return 1'b0;
    return (timeslot == 6'h3F) || (s == int'(timeslot)) || (role && s == 0);
  endfunction

  function automatic bit expOkF();
    return (mPh == P_WAIT) && req[mOwner] && mySlotF();
  endfunction

  function automatic bit expAbortF();
    return (mPh == P_BUSY) && !txDone && (mT - mOkT == TOUT);
  endfunction

  function automatic int pickF(input logic [1:0] e);
    return e[mRr] ? mRr : 1 - mRr;
  endfunction

  function automatic int costOf(input logic [1:0] s);
    case (s)
      2'd0: return 5;
      2'd1: return 9;
      2'd2: return 17;
      default: return 27;
    endcase
  endfunction

  function automatic logic [15:0] nextEF();
    int cost;
    cost = (rxPulse ? 4 : 0) + (expOkF() ? costOf(txSetting) : 0);
    return (int'(mE) > cost) ? 16'(int'(mE) - cost) : 16'h0000;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mT <= 0;
      mPh <= P_IDLE;
      mOwner <= 0;
      mRr <= 0;
      mOkT <= 0;
      mE <= EINIT;
      mLow <= 1'b0;
    end else begin
      mT <= mT + 1;
`ifdef ENERGY_ACCT_EN
      mE <= nextEF();
      mLow <= (mE < ETH);
`endif
      case (mPh)
        P_IDLE: if (|effReqF()) mPh <= P_ARB;
        P_ARB: begin
          if (|effReqF()) begin
            mOwner <= pickF(effReqF());
            mRr <= 1 - pickF(effReqF());
            mPh <= P_WAIT;
          end else begin
            mPh <= P_IDLE;
          end
        end
        P_WAIT: begin
          if (!req[mOwner]) mPh <= P_IDLE;
          else if (mySlotF()) begin
            mPh <= P_BUSY;
            mOkT <= mT;
          end
        end
        P_BUSY: if (txDone || (mT - mOkT == TOUT)) mPh <= P_DONE;
        default: mPh <= P_IDLE;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, mT, act, exp);
    end
  endtask

  logic [1:0] eGrant, eGd;
  always @(negedge clk) begin
    eGrant = ((mPh == P_WAIT) || (mPh == P_BUSY)) ? 2'(1 << mOwner) : 2'b00;
    eGd = (mPh == P_DONE) ? 2'(1 << mOwner) : 2'b00;
    chk("grant", 32'(grant), 32'(eGrant));
    chk("okToSend", 32'(okToSend), 32'(expOkF()));
    chk("grant_done", 32'(grantDone), 32'(eGd));
    chk("tx_abort", 32'(txAbort), 32'(expAbortF()));
    chk("slot_idx", 32'(slotIdx), 32'((mT / SLOT) % FRAME));
    chk("myEnergy", 32'(myEnergy), 32'(mE));
    chk("low_E", 32'(lowE), 32'(mLow));
    if (grantDone !== 2'b00)
      $display("txn t=%0d grant_done=%b", mT, grantDone);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    nrst = 1'b0;
    req = 2'b00;
    txDone = 1'b0;
    rxPulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic waitUntil(input int t);
    for (int i = 0; i < 2000 && mT < t; i++) cyc();
  endtask

  task automatic waitOk(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (okToSend === 1'b1) begin
        at = mT;
        break;
      end
    end
  endtask

  task automatic waitAbort(output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txAbort === 1'b1) begin
        at = mT;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0d", mT);
    $fatal(1, "watchdog");
  end

  initial begin
    int at, tab;

    // Assigned slot 5 with a simultaneous rx at the strobe.
    timeslot = 6'd5;
    role = 1'b0;
    txSetting = 2'd3;
    doReset();
    @(negedge clk);
    chk("rst_energy", 32'(myEnergy), 32'(EINIT));
    chk("rst_grant", 32'(grant), 32'd0);
    req = 2'b01;
    waitUntil(80);
    rxPulse = 1'b1;
    @(negedge clk);
    chk("t1_ok", 32'(okToSend), 32'd1);
    chk("t1_slot", 32'(slotIdx), 32'd5);
    cyc();
    rxPulse = 1'b0;
    @(negedge clk);
    chk("t4_energy", 32'(myEnergy), 32'(T4_E));
    cyc();
    cyc();
    txDone = 1'b1;
    cyc();
    txDone = 1'b0;
    req = 2'b00;
    @(negedge clk);
    chk("t1_gdone", 32'(grantDone), 32'b01);

    // Round robin with both sources requesting.
    timeslot = 6'h3F;
    doReset();
    req = 2'b11;
    waitOk(100, at);
    chk("rr_grant1", 32'(grant), 32'b01);
    cyc();
    txDone = 1'b1;
    cyc();
    txDone = 1'b0;
    @(negedge clk);
    chk("rr_gd1", 32'(grantDone), 32'b01);
    waitOk(100, at);
    chk("rr_grant2", 32'(grant), 32'b10);
    cyc();
    txDone = 1'b1;
    cyc();
    txDone = 1'b0;
    req = 2'b00;
    @(negedge clk);
    chk("rr_gd2", 32'(grantDone), 32'b10);

    // Contention slot and timeout.
    doReset();
    waitUntil(20);
    req = 2'b01;
    waitOk(100, at);
    chk("cont_okAt", 32'(at), 32'd32);
    waitAbort(tab);
    chk("abort_delay", 32'(tab - at), 32'd64);
    cyc();
    @(negedge clk);
    chk("abort_gd", 32'(grantDone), 32'b01);
    cyc();
    req = 2'b00;
    cyc();
    @(negedge clk);
    chk("abort_idle", 32'(grant), 32'd0);

    // tx_done coinciding with the timeout counts as completion.
    doReset();
    req = 2'b01;
    waitOk(100, at);
    waitUntil(at + 64);
    txDone = 1'b1;
    @(negedge clk);
    chk("tie_abort", 32'(txAbort), 32'd0);
    cyc();
    txDone = 1'b0;
    req = 2'b00;
    @(negedge clk);
    chk("tie_gd", 32'(grantDone), 32'b01);

    // Cluster head takes slot 0 before its own slot 10.
    timeslot = 6'd10;
    role = 1'b1;
    doReset();
    waitUntil(200);
    req = 2'b01;
    waitOk(700, at);
    chk("ch_okAt", 32'(at), 32'd512);
    cyc();
    txDone = 1'b1;
    cyc();
    txDone = 1'b0;
    req = 2'b00;
    role = 1'b0;

    // Request withdrawn while waiting for the slot.
    timeslot = 6'd5;
    doReset();
    waitUntil(10);
    req = 2'b01;
    waitUntil(40);
    req = 2'b00;
    cyc();
    @(negedge clk);
    chk("drop_grant", 32'(grant), 32'd0);
    waitUntil(100);

    // Reset in the middle of a transmission.
    timeslot = 6'h3F;
    doReset();
    req = 2'b01;
    waitOk(100, at);
    repeat (5) cyc();
    #2;
    nrst = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_gd", 32'(grantDone), 32'd0);
    chk("mid_rst_ok", 32'(okToSend), 32'd0);
    chk("mid_rst_abort", 32'(txAbort), 32'd0);
    chk("mid_rst_slot", 32'(slotIdx), 32'd0);
    chk("mid_rst_energy", 32'(myEnergy), 32'(EINIT));
    req = 2'b00;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (4) cyc();

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0)
        timeslot = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom_range(0, 31));
      if ($urandom_range(0, 299) == 0) role = ~role;
      txSetting = 2'($urandom_range(0, 3));
      rxPulse = ($urandom_range(0, 7) == 0);
      txDone = ($urandom_range(0, 24) == 0);
      cyc();
    end
    req = 2'b00;
    rxPulse = 1'b0;
    txDone = 1'b0;
    role = 1'b0;

`ifdef ENERGY_ACCT_EN
    // Drain energy to the low threshold, then to saturation.
    timeslot = 6'h3F;
    txSetting = 2'd0;
    doReset();
    req = 2'b01;
    waitOk(100, at);
    cyc();
    txDone = 1'b1;
    cyc();
    txDone = 1'b0;
    req = 2'b00;
    @(negedge clk);
    chk("e_first_tx", 32'(myEnergy), 32'h7FFB);
    cyc();
    rxPulse = 1'b1;
    repeat (7678) cyc();
    rxPulse = 1'b0;
    @(negedge clk);
    chk("e_0803", 32'(myEnergy), 32'h0803);
    req = 2'b01;
    waitOk(100, at);
    chk("e_pre_low", 32'(lowE), 32'd0);
    cyc();
    @(negedge clk);
    chk("e_07FE", 32'(myEnergy), 32'h07FE);
    chk("e_low_lag", 32'(lowE), 32'd0);
    cyc();
    txDone = 1'b1;
    @(negedge clk);
    chk("e_low_set", 32'(lowE), 32'd1);
    cyc();
    txDone = 1'b0;
    req = 2'b00;
    cyc();
    req = 2'b10;
    repeat (40) cyc();
    @(negedge clk);
    chk("mask_grant", 32'(grant), 32'd0);
    req = 2'b11;
    waitOk(100, at);
    chk("mask_req0", 32'(grant), 32'b01);
    cyc();
    txDone = 1'b1;
    cyc();
    txDone = 1'b0;
    req = 2'b00;
    cyc();
    rxPulse = 1'b1;
    repeat (600) cyc();
    rxPulse = 1'b0;
    @(negedge clk);
    chk("e_saturate", 32'(myEnergy), 32'h0000);
    chk("e_sat_low", 32'(lowE), 32'd1);
`endif

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
